// File: rtl/mod_accum_if.sv
// Stream bus for mod_accum: residue beats in, one reduced frame sum out.
// out_err exists only when MODACC_RANGE_CHECK_EN is defined.
interface mod_accum_if #(
    parameter int K = 54
);
    logic [K-1:0] q;
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_data;
`ifdef MODACC_RANGE_CHECK_EN
    logic         out_err;
`endif

    modport master (
        output q, in_valid, in_data, in_last, out_ready,
`ifdef MODACC_RANGE_CHECK_EN
        input  out_err,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  q, in_valid, in_data, in_last, out_ready,
`ifdef MODACC_RANGE_CHECK_EN
        output out_err,
`endif
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mod_accum.sv
// Streaming modular accumulator: one residue/cycle into ping-pong banks, one sum mod q per frame.
// Latency: out_valid rises 4 cycles after the edge accepting in_last.
// Backpressure: in_ready drops from last-beat accept until the output handshake; out_data held while out_ready low.
// Optional range check (sticky out_err) enabled by defining MODACC_RANGE_CHECK_EN.
module mod_accum #(
    parameter int K = 54
) (
    input  logic        clk,
    input  logic        rst_n,
    mod_accum_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, COMBINE, DONE} state_t;

    state_t       state;
    logic         cnt;
    logic         par;
    logic [K-1:0] q_reg;
    logic [K-1:0] bank0;
    logic [K-1:0] bank1;
    logic         s1_vld;
    logic         s1_cmb;
    logic         s1_bank;
    logic [K:0]   s1_raw;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [K-1:0] out_data_r;
    logic [K:0]   red_full;
    logic         acc;

    assign acc           = bus.in_valid & in_ready_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    // Second adder stage: conditional subtract of the frame's modulus.
    always_comb begin
        red_full = s1_raw;
        if (s1_raw >= {1'b0, q_reg})
            red_full = s1_raw - {1'b0, q_reg};
    end

`ifdef MODACC_RANGE_CHECK_EN
    logic         err;
    logic [K-1:0] q_eff;
    assign q_eff       = (state == IDLE) ? bus.q : q_reg;
    assign bus.out_err = err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 1'b0;
            par         <= 1'b0;
            q_reg       <= '0;
            bank0       <= '0;
            bank1       <= '0;
            s1_vld      <= 1'b0;
            s1_cmb      <= 1'b0;
            s1_bank     <= 1'b0;
            s1_raw      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
`ifdef MODACC_RANGE_CHECK_EN
            err         <= 1'b0;
`endif
        end else begin
            s1_vld <= 1'b0;
            if (s1_vld) begin
                if (s1_cmb)
                    out_data_r <= red_full[K-1:0];
                else if (s1_bank)
                    bank1 <= red_full[K-1:0];
                else
                    bank0 <= red_full[K-1:0];
            end

            case (state)
                IDLE, ACCUM: begin
                    if (acc) begin
                        s1_vld  <= 1'b1;
                        s1_cmb  <= 1'b0;
                        s1_bank <= par;
                        s1_raw  <= {1'b0, (par ? bank1 : bank0)} + {1'b0, bus.in_data};
                        par     <= ~par;
                        if (state == IDLE)
                            q_reg <= bus.q;
`ifdef MODACC_RANGE_CHECK_EN
                        if (bus.in_data >= q_eff)
                            err <= 1'b1;
`endif
                        if (bus.in_last) begin
                            state      <= DRAIN;
                            in_ready_r <= 1'b0;
                            cnt        <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                // Two cycles lets the last beat's bank write settle before combining.
                DRAIN: begin
                    cnt <= ~cnt;
                    if (cnt)
                        state <= COMBINE;
                end
                COMBINE: begin
                    cnt <= ~cnt;
                    if (!cnt) begin
                        s1_vld <= 1'b1;
                        s1_cmb <= 1'b1;
                        s1_raw <= {1'b0, bank0} + {1'b0, bank1};
                    end else begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        bank0       <= '0;
                        bank1       <= '0;
                        par         <= 1'b0;
`ifdef MODACC_RANGE_CHECK_EN
                        err         <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_accum.sv
// Scoreboard bench for mod_accum: directed frames push expected sums, a monitor pops on each output handshake.
module tb_mod_accum;
    localparam int K = 54;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_accum_if #(.K(K)) bus ();

    mod_accum #(.K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [K-1:0] data;
        bit           chk_data;
        bit           err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_data)
                    chk("sum", {10'd0, bus.out_data}, {10'd0, e.data});
`ifdef MODACC_RANGE_CHECK_EN
                chk("out_err", {63'd0, bus.out_err}, {63'd0, e.err});
`endif
            end
        end
    end

    // Presents one beat at a negedge and holds it until accepted; returns just after the accepting edge.
    task automatic drive_beat(input logic [K-1:0] qv, input logic [K-1:0] d, input bit last,
                              output int waited);
        waited = 0;
        @(negedge clk);
        bus.q        = qv;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic push_exp(input logic [K-1:0] d, input bit cd, input bit e);
        exp_t x;
        x.data = d; x.chk_data = cd; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    logic [K-1:0] v1 [3];
    int w;

    initial begin
        bus.q = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        v1[0] = 54'd5; v1[1] = 54'd9; v1[2] = 54'd16;

        #12;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_data", {10'd0, bus.out_data}, 64'd0);
`ifdef MODACC_RANGE_CHECK_EN
        chk("rst_out_err", {63'd0, bus.out_err}, 64'd0);
`endif
        @(negedge clk); rst_n = 1'b1;

        // 1: {5,9,16} q=17 -> 13, latency 4 edges
        push_exp(54'd13, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_beat(54'd17, v1[i], (i == 2), w);
            chk("t1_no_stall", w, 0);
        end
        chk("t1_lat0", {63'd0, bus.out_valid}, 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("t1_latency", {63'd0, bus.out_valid}, (k == 4) ? 64'd1 : 64'd0);
        end
        wait_idle();

        // 2: single beat 7 -> 7; in_ready low until handshake
        push_exp(54'd7, 1'b1, 1'b0);
        drive_beat(54'd17, 54'd7, 1'b1, w);
        for (int k = 0; k <= 5; k++) begin
            chk("t2_in_ready", {63'd0, bus.in_ready}, (k == 5) ? 64'd1 : 64'd0);
            if (k < 5) begin @(posedge clk); #1; end
        end

        // 3: 8 x 16 q=17 -> 9, no stall
        push_exp(54'd9, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_beat(54'd17, 54'd16, (i == 7), w);
            chk("t3_no_stall", w, 0);
        end
        wait_idle();

        // 4: {3,4} q=11, output stalled 10 cycles
        bus.out_ready = 1'b0;
        push_exp(54'd7, 1'b1, 1'b0);
        drive_beat(54'd11, 54'd3, 1'b0, w);
        drive_beat(54'd11, 54'd4, 1'b1, w);
        begin
            int t = 0;
            while (!bus.out_valid && t < 20) begin @(posedge clk); #1; t++; end
            chk("t4_valid_seen", {63'd0, bus.out_valid}, 64'd1);
        end
        for (int k = 0; k < 10; k++) begin
            chk("t4_hold_data", {10'd0, bus.out_data}, 64'd7);
            chk("t4_hold_rdy", {63'd0, bus.in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_release_rdy", {63'd0, bus.in_ready}, 64'd1);

        // 5: reset mid-frame, then {1,2} -> 3
        drive_beat(54'd17, 54'd10, 1'b0, w);
        drive_beat(54'd17, 54'd11, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_rdy", {63'd0, bus.in_ready}, 64'd1);
        chk("t5_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t5_rst_data", {10'd0, bus.out_data}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        push_exp(54'd3, 1'b1, 1'b0);
        drive_beat(54'd17, 54'd1, 1'b0, w);
        drive_beat(54'd17, 54'd2, 1'b1, w);
        wait_idle();

`ifdef MODACC_RANGE_CHECK_EN
        // 6: out-of-range beat flags out_err; next frame clean
        push_exp(54'd0, 1'b0, 1'b1);
        drive_beat(54'd17, 54'd20, 1'b0, w);
        drive_beat(54'd17, 54'd1, 1'b1, w);
        wait_idle();
        push_exp(54'd1, 1'b1, 1'b0);
        drive_beat(54'd17, 54'd1, 1'b1, w);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
